// File: rtl/pkg_tpu.sv
// Shared types for the TPU lane scalar-data transfer logic.
package pkg_tpu;

    typedef enum logic {
        SXFER_GATHER = 1'b0,
        SXFER_BCAST  = 1'b1
    } sxfer_dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BCAST  = 2'd1,
        ST_GATHER = 2'd2,
        ST_DONE   = 2'd3
    } sxfer_state_t;

    // Lane index width, never narrower than one bit.
    function automatic int unsigned lane_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_sdata_xfer_ctrl_if.sv
// Scalar-unit side of the lane scalar-data transfer: request port and gather stream.
interface lane_sdata_xfer_ctrl_if
    import pkg_tpu::*;
#(
    parameter int unsigned NUM_LANES  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_W     = lane_w(NUM_LANES)
);
    logic                  I_Req_Valid;
    logic                  I_Req_Dir;
    logic [NUM_LANES-1:0]  I_Req_Mask;
    logic [DATA_WIDTH-1:0] I_Bcast_Data;
    logic                  O_Req_Ready;

    logic                  O_Gth_Valid;
    logic [DATA_WIDTH-1:0] O_Gth_Data;
    logic [LANE_W-1:0]     O_Gth_Lane;
    logic                  O_Gth_Last;
    logic                  I_Gth_Ready;

    modport master (
        output I_Req_Valid, I_Req_Dir, I_Req_Mask, I_Bcast_Data, I_Gth_Ready,
        input  O_Req_Ready, O_Gth_Valid, O_Gth_Data, O_Gth_Lane, O_Gth_Last
    );

    modport slave (
        input  I_Req_Valid, I_Req_Dir, I_Req_Mask, I_Bcast_Data, I_Gth_Ready,
        output O_Req_Ready, O_Gth_Valid, O_Gth_Data, O_Gth_Lane, O_Gth_Last
    );
endinterface

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit encoder over a lane mask, with any-set and single-bit-left flags.
module lane_prio_enc
    import pkg_tpu::*;
#(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned LANE_W    = lane_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] vec,
    output logic [LANE_W-1:0]    idx,
    output logic                 any_set,
    output logic                 one_left
);
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (vec[i] && !any_set) begin
                idx     = LANE_W'(i);
                any_set = 1'b1;
            end
        end
        one_left = any_set && ((vec & (vec - NUM_LANES'(1))) == '0);
    end
endmodule

// File: rtl/lane_sdata_xfer_ctrl.sv
// Broadcast/gather sequencer between the scalar unit and the per-lane scalar data registers.
module lane_sdata_xfer_ctrl
    import pkg_tpu::*;
#(
    parameter int unsigned NUM_LANES  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_W     = lane_w(NUM_LANES)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            I_Stall,
    lane_sdata_xfer_ctrl_if.slave           bus,
    output logic [NUM_LANES-1:0]            O_SWe,
    output logic [DATA_WIDTH-1:0]           O_Scalar_Data,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] I_Lane_SData,
    output logic                            O_Busy,
    output logic                            O_Done
);
    sxfer_state_t          state_q, state_d;
    logic [NUM_LANES-1:0]  mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LANE_W-1:0]     cur_lane;
    logic                  any_left, one_left;
    logic [DATA_WIDTH-1:0] lane_data;

    lane_prio_enc #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_prio_enc (
        .vec      (mask_q),
        .idx      (cur_lane),
        .any_set  (any_left),
        .one_left (one_left)
    );

    always_comb begin
        lane_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (cur_lane == LANE_W'(i))
                lane_data = I_Lane_SData[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        data_d          = data_q;
        bus.O_Req_Ready = 1'b0;
        bus.O_Gth_Valid = 1'b0;
        bus.O_Gth_Data  = '0;
        bus.O_Gth_Lane  = '0;
        bus.O_Gth_Last  = 1'b0;
        O_SWe           = '0;
        O_Scalar_Data   = '0;
        O_Done          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bus.O_Req_Ready = ~I_Stall;
                if (bus.I_Req_Valid && !I_Stall) begin
                    mask_d = bus.I_Req_Mask;
                    data_d = bus.I_Bcast_Data;
                    // Direction is carried by the next state rather than a separate register.
                    if (bus.I_Req_Mask == '0)
                        state_d = ST_DONE;
                    else if (bus.I_Req_Dir == SXFER_BCAST)
                        state_d = ST_BCAST;
                    else
                        state_d = ST_GATHER;
                end
            end
            ST_BCAST: begin
                O_Scalar_Data = data_q;
                if (!I_Stall) begin
                    O_SWe   = mask_q;
                    state_d = ST_DONE;
                end
            end
            ST_GATHER: begin
                bus.O_Gth_Valid = ~I_Stall;
                bus.O_Gth_Data  = lane_data;
                bus.O_Gth_Lane  = cur_lane;
                bus.O_Gth_Last  = one_left;
                if (!any_left) begin
                    state_d = ST_DONE;
                end else if (!I_Stall && bus.I_Gth_Ready) begin
                    mask_d = mask_q & ~(NUM_LANES'(1) << cur_lane);
                    if (one_left)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!I_Stall) begin
                    O_Done  = 1'b1;
                    mask_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign O_Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lane_sdata_xfer_ctrl.sv
// Scoreboard bench for lane_sdata_xfer_ctrl: broadcast, gather, backpressure, stall, reset abort.
module tb_lane_sdata_xfer_ctrl;
    localparam int unsigned NL = 16;
    localparam int unsigned DW = 32;

    localparam int K_BEAT = 0;
    localparam int K_SWE  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [3:0]  lane;
        logic [31:0] data;
        logic        last;
        logic [15:0] mask;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             stall;
    logic [NL-1:0]    swe;
    logic [DW-1:0]    sdata;
    logic [NL*DW-1:0] lane_sdata;
    logic             busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    lane_sdata_xfer_ctrl_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus_if ();

    lane_sdata_xfer_ctrl #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .I_Stall       (stall),
        .bus           (bus_if),
        .O_SWe         (swe),
        .O_Scalar_Data (sdata),
        .I_Lane_SData  (lane_sdata),
        .O_Busy        (busy),
        .O_Done        (done)
    );

    always #5 clock = ~clock;

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beat(logic [3:0] l, logic [31:0] d, logic lst);
        exp_t e;
        e = '{kind: K_BEAT, lane: l, data: d, last: lst, mask: '0};
        sb.push_back(e);
    endtask

    task automatic push_swe(logic [15:0] m, logic [31:0] d);
        exp_t e;
        e = '{kind: K_SWE, lane: '0, data: d, last: 1'b0, mask: m};
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '{kind: K_DONE, lane: '0, data: '0, last: 1'b0, mask: '0};
        sb.push_back(e);
    endtask

    // Call at posedge+1; the request is accepted on the next rising edge.
    task automatic send(logic d, logic [15:0] m, logic [31:0] v);
        bus_if.I_Req_Valid  = 1'b1;
        bus_if.I_Req_Dir    = d;
        bus_if.I_Req_Mask   = m;
        bus_if.I_Bcast_Data = v;
        @(negedge clock);
        check_val("req_ready_at_send", bus_if.O_Req_Ready, 1);
        tick();
        bus_if.I_Req_Valid = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus_if.O_Gth_Valid && bus_if.I_Gth_Ready) begin
            check_val("beat_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("beat_kind", e.kind, K_BEAT);
                check_val("beat_lane", bus_if.O_Gth_Lane, e.lane);
                check_val("beat_data", bus_if.O_Gth_Data, e.data);
                check_val("beat_last", bus_if.O_Gth_Last, e.last);
            end
        end
        if (swe != '0) begin
            check_val("swe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("swe_kind", e.kind, K_SWE);
                check_val("swe_mask", swe, e.mask);
                check_val("swe_data", sdata, e.data);
            end
        end
        if (done) begin
            check_val("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("done_kind", e.kind, K_DONE);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] lanes8013 [4];
        lanes8013 = '{4'd0, 4'd1, 4'd4, 4'd15};

        reset = 1'b1;
        stall = 1'b0;
        bus_if.I_Req_Valid  = 1'b0;
        bus_if.I_Req_Dir    = 1'b0;
        bus_if.I_Req_Mask   = '0;
        bus_if.I_Bcast_Data = '0;
        bus_if.I_Gth_Ready  = 1'b1;
        for (int i = 0; i < NL; i++)
            lane_sdata[i*DW +: DW] = 32'(32'h100 + i);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_ready", bus_if.O_Req_Ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_swe", swe, 0);
        check_val("rst_done", done, 0);
        check_val("rst_gvalid", bus_if.O_Gth_Valid, 0);
        tick();

        // Broadcast 0x00A5
        push_swe(16'h00A5, 32'hDEAD_BEEF);
        push_done();
        send(1'b1, 16'h00A5, 32'hDEAD_BEEF);
        @(negedge clock);
        check_val("bc_swe", swe, 16'h00A5);
        check_val("bc_data", sdata, 32'hDEAD_BEEF);
        check_val("bc_gvalid", bus_if.O_Gth_Valid, 0);
        check_val("bc_done_early", done, 0);
        tick();
        @(negedge clock);
        check_val("bc_swe_once", swe, 0);
        check_val("bc_done", done, 1);
        tick();
        @(negedge clock);
        check_val("bc_done_pulse", done, 0);
        check_val("bc_idle", busy, 0);
        tick();

        // Gather 0x8013, ready held high
        for (int k = 0; k < 4; k++)
            push_beat(lanes8013[k], 32'(32'h100 + lanes8013[k]), k == 3);
        push_done();
        send(1'b0, 16'h8013, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_val("g1_valid", bus_if.O_Gth_Valid, 1);
            check_val("g1_lane", bus_if.O_Gth_Lane, lanes8013[k]);
            check_val("g1_last", bus_if.O_Gth_Last, k == 3);
            tick();
        end
        @(negedge clock);
        check_val("g1_done", done, 1);
        check_val("g1_no_beat", bus_if.O_Gth_Valid, 0);
        tick();
        tick();

        // Gather 0x0006 with backpressure
        bus_if.I_Gth_Ready = 1'b0;
        push_beat(4'd1, 32'h101, 1'b0);
        push_beat(4'd2, 32'h102, 1'b1);
        push_done();
        send(1'b0, 16'h0006, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_val("bp_valid", bus_if.O_Gth_Valid, 1);
            check_val("bp_lane", bus_if.O_Gth_Lane, 1);
            check_val("bp_data", bus_if.O_Gth_Data, 32'h101);
            check_val("bp_last", bus_if.O_Gth_Last, 0);
            tick();
        end
        bus_if.I_Gth_Ready = 1'b1;
        tick();
        @(negedge clock);
        check_val("bp_lane2", bus_if.O_Gth_Lane, 2);
        check_val("bp_last2", bus_if.O_Gth_Last, 1);
        tick();
        @(negedge clock);
        check_val("bp_done", done, 1);
        tick();
        tick();

        // Empty mask, both directions
        for (int d = 0; d < 2; d++) begin
            push_done();
            send(d[0], 16'h0000, 32'h5555_5555);
            @(negedge clock);
            check_val("z_done", done, 1);
            check_val("z_swe", swe, 0);
            check_val("z_gvalid", bus_if.O_Gth_Valid, 0);
            tick();
            tick();
        end

        // Stall in IDLE, then stall during gather 0x0003
        stall = 1'b1;
        @(negedge clock);
        check_val("st_idle_ready", bus_if.O_Req_Ready, 0);
        tick();
        stall = 1'b0;
        push_beat(4'd0, 32'h100, 1'b0);
        push_beat(4'd1, 32'h101, 1'b1);
        push_done();
        send(1'b0, 16'h0003, '0);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check_val("st_gvalid", bus_if.O_Gth_Valid, 0);
            check_val("st_busy", busy, 1);
            check_val("st_ready", bus_if.O_Req_Ready, 0);
            tick();
        end
        stall = 1'b0;
        @(negedge clock);
        check_val("st_lane0", bus_if.O_Gth_Lane, 0);
        check_val("st_valid0", bus_if.O_Gth_Valid, 1);
        tick();
        @(negedge clock);
        check_val("st_lane1", bus_if.O_Gth_Lane, 1);
        check_val("st_last1", bus_if.O_Gth_Last, 1);
        tick();
        @(negedge clock);
        check_val("st_done", done, 1);
        tick();
        tick();

        // Reset during gather 0xFFFF after the first beat
        push_beat(4'd0, 32'h100, 1'b0);
        send(1'b0, 16'hFFFF, '0);
        reset = 1'b1;
        @(negedge clock);
        check_val("ra_first_lane", bus_if.O_Gth_Lane, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_val("ra_busy", busy, 0);
        check_val("ra_done", done, 0);
        check_val("ra_swe", swe, 0);
        check_val("ra_sdata", sdata, 0);
        check_val("ra_gvalid", bus_if.O_Gth_Valid, 0);
        check_val("ra_gdata", bus_if.O_Gth_Data, 0);
        check_val("ra_glane", bus_if.O_Gth_Lane, 0);
        check_val("ra_glast", bus_if.O_Gth_Last, 0);
        check_val("ra_ready", bus_if.O_Req_Ready, 1);
        repeat (4) tick();

        push_swe(16'h0F0F, 32'h1234_5678);
        push_done();
        send(1'b1, 16'h0F0F, 32'h1234_5678);
        @(negedge clock);
        check_val("ra_bc_swe", swe, 16'h0F0F);
        tick();
        @(negedge clock);
        check_val("ra_bc_done", done, 1);
        repeat (3) tick();

        check_val("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
